// File: rtl/pg_alu_seq.sv
// rtl/pg_alu_seq.sv - power-gated ALU with power sequencer and always-on result retention
module pg_alu_seq #(
    parameter int WIDTH        = 16,
    parameter int ISO_CYCLES   = 2,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    input  logic             sleep_req,
    input  logic             pwr_ack,
    output logic             alu_pwr_en,
    output logic             iso_en,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic             result_valid,
    output logic [2:0]       pwr_state
);
    localparam int SHW = $clog2(WIDTH);
    localparam int ISO_W = (ISO_CYCLES < 2) ? 1 : $clog2(ISO_CYCLES);
    localparam logic [ISO_W-1:0] ISO_LAST = ISO_W'(ISO_CYCLES - 1);
    localparam int IDLE_W = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PWR_UP = 3'd1,
        S_DEISO  = 3'd2,
        S_ON     = 3'd3,
        S_BUSY   = 3'd4,
        S_ISO    = 3'd5,
        S_PWR_DN = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [ISO_W-1:0]   iso_cnt_q, iso_cnt_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   result_q;
    logic [2:0]         flags_q;
    logic               result_valid_q;

    logic               hs, idle_hit, load_en;
    logic [WIDTH-1:0]   alu_res, res_iso;
    logic               alu_carry, alu_err;
    logic [2:0]         flags_iso;

    assign hs       = in_valid & in_ready;
    assign idle_hit = (IDLE_TIMEOUT != 0) && (idle_q == IDLE_MAX);

    always_comb begin
        state_d    = state_q;
        alu_pwr_en = 1'b1;
        iso_en     = 1'b1;
        in_ready   = 1'b0;
        case (state_q)
            S_OFF: begin
                alu_pwr_en = 1'b0;
                if (in_valid && !sleep_req) state_d = S_PWR_UP;
            end
            S_PWR_UP: if (pwr_ack) state_d = S_DEISO;
            S_DEISO:  if (iso_cnt_q == ISO_LAST) state_d = S_ON;
            S_ON: begin
                iso_en   = 1'b0;
                in_ready = 1'b1;
                if (in_valid)                   state_d = S_BUSY;
                else if (sleep_req || idle_hit) state_d = S_ISO;
            end
            S_BUSY: begin
                iso_en  = 1'b0;
                state_d = S_ON;
            end
            S_ISO:    if (iso_cnt_q == ISO_LAST) state_d = S_PWR_DN;
            S_PWR_DN: begin
                alu_pwr_en = 1'b0;
                if (!pwr_ack) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    // Isolation dwell counter is shared by DEISO and ISO; it idles at zero elsewhere.
    always_comb begin
        iso_cnt_d = '0;
        if ((state_q == S_DEISO || state_q == S_ISO) && iso_cnt_q != ISO_LAST)
            iso_cnt_d = iso_cnt_q + 1'b1;
        idle_d = '0;
        if (state_q == S_ON && !hs)
            idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
    end

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (op_q)
            4'd0: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            4'd1: {alu_carry, alu_res} = {1'b0, a_q} - {1'b0, b_q};
            4'd2: alu_res = a_q & b_q;
            4'd3: alu_res = a_q | b_q;
            4'd4: alu_res = a_q ^ b_q;
            4'd5: alu_res = ~a_q;
            4'd6: alu_res = a_q << b_q[SHW-1:0];
            4'd7: alu_res = a_q >> b_q[SHW-1:0];
            4'd8: alu_res = a_q * b_q;
            4'd9: alu_res = b_q;
            default: alu_err = 1'b1;
        endcase
    end

    // Clamp the gated-domain output at the always-on boundary.
    assign load_en   = (state_q == S_BUSY) && !iso_en && alu_pwr_en;
    assign res_iso   = load_en ? alu_res : '0;
    assign flags_iso = load_en ? {alu_err, alu_carry, (alu_res == '0)} : 3'b000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_OFF;
            iso_cnt_q      <= '0;
            idle_q         <= '0;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            result_q       <= '0;
            flags_q        <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            iso_cnt_q      <= iso_cnt_d;
            idle_q         <= idle_d;
            result_valid_q <= load_en;
            if (hs) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= opcode;
            end
            if (load_en) begin
                result_q <= res_iso;
                flags_q  <= flags_iso;
            end
        end
    end

    assign result       = result_q;
    assign flags        = flags_q;
    assign result_valid = result_valid_q;
    assign pwr_state    = state_q;
endmodule

// File: tb/tb_pg_alu_seq.sv
// tb/tb_pg_alu_seq.sv - directed and randomized checks for pg_alu_seq
module tb_pg_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, sleep_req, pwr_ack;
    logic        alu_pwr_en, iso_en, result_valid;
    logic [15:0] a, b, result;
    logic [3:0]  opcode;
    logic [2:0]  flags, pwr_state;
    logic [2:0]  ack_sr = 3'b000;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    // Power switch responds three cycles after the enable changes.
    always @(posedge clk) ack_sr <= {ack_sr[1:0], alu_pwr_en};
    assign pwr_ack = ack_sr[2];

    pg_alu_seq #(.WIDTH(16), .ISO_CYCLES(2), .IDLE_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .sleep_req(sleep_req), .pwr_ack(pwr_ack),
        .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .result(result), .flags(flags),
        .result_valid(result_valid), .pwr_state(pwr_state)
    );

    function automatic logic [18:0] ref_alu(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] w;
        logic [15:0] r;
        logic        c, e;
        r = 16'h0; c = 1'b0; e = 1'b0;
        case (op)
            4'd0: begin w = {1'b0, x} + {1'b0, y}; r = w[15:0]; c = w[16]; end
            4'd1: begin r = x - y; c = (x < y); end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ~x;
            4'd6: r = x << y[3:0];
            4'd7: r = x >> y[3:0];
            4'd8: r = x * y;
            4'd9: r = y;
            default: e = 1'b1;
        endcase
        return {e, c, (r == 16'h0), r};
    endfunction

    task automatic wait_state(input logic [2:0] st, input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < budget) begin
            if (pwr_state == st) begin ok = 1'b1; break; end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wake(output bit ok);
        int n;
        in_valid = 1'b1; sleep_req = 1'b0; opcode = 4'd9; a = 16'h0; b = 16'h0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_state(3'd3, 50, n, ok);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] res, output logic [2:0] flg,
                         output logic [2:0] busy_st, output logic rv1, output logic rv2);
        in_valid = 1'b1; a = x; b = y; opcode = op;
        @(negedge clk);
        busy_st = pwr_state; rv1 = result_valid; in_valid = 1'b0;
        @(negedge clk);
        rv2 = result_valid; res = result; flg = flags;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; sleep_req = 1'b0; a = 16'h0; b = 16'h0; opcode = 4'd0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (pwr_state !== 3'd0 || alu_pwr_en !== 1'b0 || iso_en !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got st=%0d pwr=%b iso=%b rdy=%b want st=0 pwr=0 iso=1 rdy=0", pwr_state, alu_pwr_en, iso_en, in_ready);
        end
        tests_run++;
        if (result !== 16'h0 || flags !== 3'b000 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got res=%h flg=%b rv=%b want 0000 000 0", result, flags, result_valid);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++;
        if (pwr_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_idle_off: got st=%0d want 0", pwr_state);
        end
    endtask

    task automatic test_cold_wake_add();
        logic [2:0] exp_st [8];
        int n_rv;
        exp_st = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
        n_rv = 0;
        in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; opcode = 4'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (result_valid) n_rv++;
            tests_run++;
            if (pwr_state !== exp_st[i]) begin
                tests_failed++;
                $display("FAIL wake_seq[%0d]: got st=%0d want %0d", i, pwr_state, exp_st[i]);
            end
            if (i == 7) in_valid = 1'b0;
        end
        @(negedge clk);
        if (result_valid) n_rv++;
        tests_run++;
        if (result_valid !== 1'b1 || result !== 16'h0000 || flags !== 3'b011 || pwr_state !== 3'd3) begin
            tests_failed++;
            $display("FAIL add_result: got rv=%b res=%h flg=%b st=%0d want 1 0000 011 3", result_valid, result, flags, pwr_state);
        end
        tests_run++;
        if (n_rv != 1) begin
            tests_failed++;
            $display("FAIL add_rv_pulses: got %0d want 1", n_rv);
        end
    endtask

    task automatic test_op_sweep();
        logic [3:0]  ops [4];
        logic [15:0] av [4], bv [4], er [4];
        logic [2:0]  ef [4];
        logic [15:0] res;
        logic [2:0]  flg, bst;
        logic        rv1, rv2;
        ops = '{4'd1, 4'd8, 4'd6, 4'd12};
        av  = '{16'h0003, 16'h0100, 16'h0001, 16'h1234};
        bv  = '{16'h0005, 16'h0101, 16'h0013, 16'h5678};
        er  = '{16'hFFFE, 16'h0100, 16'h0008, 16'h0000};
        ef  = '{3'b010, 3'b000, 3'b000, 3'b101};
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], av[i], bv[i], res, flg, bst, rv1, rv2);
            tests_run++;
            if (res !== er[i] || flg !== ef[i] || rv2 !== 1'b1) begin
                tests_failed++;
                $display("FAIL sweep_op%0d: got res=%h flg=%b rv=%b want %h %b 1", ops[i], res, flg, rv2, er[i], ef[i]);
            end
            tests_run++;
            if (bst !== 3'd4 || rv1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL sweep_latency%0d: got st=%0d rv=%b want 4 0", i, bst, rv1);
            end
        end
    endtask

    task automatic test_idle_timeout();
        int k_iso, n;
        bit ok;
        k_iso = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pwr_state == 3'd5) begin k_iso = k; break; end
        end
        tests_run++;
        if (k_iso != 9) begin
            tests_failed++;
            $display("FAIL idle_iso_delay: got %0d want 9", k_iso);
        end
        wait_state(3'd0, 40, n, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL idle_reach_off: got st=%0d want 0", pwr_state);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (result !== 16'h0000 || flags !== 3'b101 || pwr_state !== 3'd0 || alu_pwr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_retention: got res=%h flg=%b st=%0d pwr=%b want 0000 101 0 0", result, flags, pwr_state, alu_pwr_en);
        end
    endtask

    task automatic test_sleep_vs_traffic();
        bit ok;
        int n, n_off;
        logic [2:0] s4, s5;
        wake(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL sv_wake: got st=%0d want 3", pwr_state); end
        in_valid = 1'b1; sleep_req = 1'b1; a = 16'h1234; b = 16'h0F0F; opcode = 4'd2;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (pwr_state !== 3'd4) begin tests_failed++; $display("FAIL sv_accept: got st=%0d want 4", pwr_state); end
        @(negedge clk);
        tests_run++;
        if (result_valid !== 1'b1 || result !== 16'h0204 || flags !== 3'b000 || pwr_state !== 3'd3) begin
            tests_failed++;
            $display("FAIL sv_result: got rv=%b res=%h flg=%b st=%0d want 1 0204 000 3", result_valid, result, flags, pwr_state);
        end
        @(negedge clk);
        tests_run++;
        if (pwr_state !== 3'd5) begin tests_failed++; $display("FAIL sv_iso_entry: got st=%0d want 5", pwr_state); end
        @(negedge clk); s4 = pwr_state;
        @(negedge clk); s5 = pwr_state;
        tests_run++;
        if (s4 !== 3'd5 || s5 !== 3'd6) begin
            tests_failed++;
            $display("FAIL sv_iso_len: got %0d,%0d want 5,6", s4, s5);
        end
        wait_state(3'd0, 30, n, ok);
        in_valid = 1'b1;
        n_off = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pwr_state == 3'd0 && alu_pwr_en == 1'b0) n_off++;
        end
        tests_run++;
        if (n_off != 10) begin
            tests_failed++;
            $display("FAIL sv_sleep_holds_off: got %0d off cycles want 10", n_off);
        end
        in_valid = 1'b0; sleep_req = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int n_rv;
        wake(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL rst_wake: got st=%0d want 3", pwr_state); end
        in_valid = 1'b1; a = 16'h0005; b = 16'h0006; opcode = 4'd0;
        @(negedge clk);
        tests_run++;
        if (pwr_state !== 3'd4) begin tests_failed++; $display("FAIL rst_busy: got st=%0d want 4", pwr_state); end
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (pwr_state !== 3'd0 || alu_pwr_en !== 1'b0 || iso_en !== 1'b1 || result !== 16'h0 || flags !== 3'b000 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_op: got st=%0d pwr=%b iso=%b res=%h flg=%b rv=%b want 0 0 1 0000 000 0", pwr_state, alu_pwr_en, iso_en, result, flags, result_valid);
        end
        rst_n = 1'b1;
        n_rv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (result_valid || pwr_state != 3'd0) n_rv++;
        end
        tests_run++;
        if (n_rv != 0) begin tests_failed++; $display("FAIL rst_no_pulse: got %0d bad cycles want 0", n_rv); end
    endtask

    task automatic test_isolation_invariant();
        int iso_viol, res_viol, sb_err, n_rv;
        logic [15:0] prev_res;
        logic [18:0] pend;
        iso_viol = 0; res_viol = 0; sb_err = 0; n_rv = 0;
        prev_res = result; pend = 19'h0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (!iso_en && (!alu_pwr_en || !pwr_ack)) iso_viol++;
            if (result !== prev_res && !result_valid) res_viol++;
            if (result_valid) begin
                n_rv++;
                if ({flags, result} !== pend) sb_err++;
            end
            prev_res  = result;
            in_valid  = ($urandom_range(0, 3) != 0);
            sleep_req = ($urandom_range(0, 15) == 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            opcode    = 4'($urandom_range(0, 15));
            if (in_valid && in_ready) pend = ref_alu(opcode, a, b);
        end
        in_valid = 1'b0; sleep_req = 1'b0;
        tests_run++;
        if (iso_viol != 0) begin tests_failed++; $display("FAIL inv_isolation: got %0d violations want 0", iso_viol); end
        tests_run++;
        if (res_viol != 0) begin tests_failed++; $display("FAIL inv_result_hold: got %0d changes without pulse want 0", res_viol); end
        tests_run++;
        if (sb_err != 0) begin tests_failed++; $display("FAIL inv_scoreboard: got %0d wrong results want 0", sb_err); end
        tests_run++;
        if (n_rv < 20) begin tests_failed++; $display("FAIL inv_activity: got %0d results want at least 20", n_rv); end
    endtask

    initial begin
        test_reset();
        test_cold_wake_add();
        test_op_sweep();
        test_idle_timeout();
        test_sleep_vs_traffic();
        test_reset_mid_op();
        test_isolation_invariant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pg_alu_seq.md
# pg_alu_seq

Parametrised power-gated ALU with an integrated power sequencer and an always-on result retention register. It wakes the ALU domain on demand, applies isolation around every power transition, and executes valid/ready operations. It returns to the gated state on request or after an idle timeout. The retained result and flags stay valid while the domain is off.

## Interface
- WIDTH, 16: operand/result width (≥4, power of two).
- ISO_CYCLES, 2: cycles isolation is held around power-up release and before power-down (≥1).
- IDLE_TIMEOUT, 8: idle ON cycles before auto power-down; 0 disables auto power-down.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  request accepted when in_valid & in_ready.
- a, b  in  WIDTH  operands.
- opcode  in  4  operation select.
- sleep_req  in  1  level request to power down.
- pwr_ack  in  1  power-switch status (1 = domain powered).
- alu_pwr_en  out  1  power-switch enable.
- iso_en  out  1  isolation clamp enable.
- result  out  WIDTH  retained (always-on) result.
- flags  out  3  retained {err, carry, zero}.
- result_valid  out  1  one-cycle pulse when result/flags update.
- pwr_state  out  3  current FSM state code.

## Operation
- FSM states and codes: OFF=0, PWR_UP=1, DEISO=2, ON=3, BUSY=4, ISO=5, PWR_DN=6.
- OFF: alu_pwr_en=0, iso_en=1, in_ready=0. If in_valid & !sleep_req, go to PWR_UP. sleep_req has priority in OFF.
- PWR_UP: alu_pwr_en=1, iso_en=1. Waits for pwr_ack=1, then goes to DEISO.
- DEISO: alu_pwr_en=1, iso_en=1 for exactly ISO_CYCLES cycles, then ON.
- ON: iso_en=0, in_ready=1.
  - A handshake captures a, b and opcode, then goes to BUSY.
  - If there is no handshake and sleep_req=1 or the idle count equals IDLE_TIMEOUT, go to ISO.
  - in_valid has priority over sleep_req.
- BUSY: in_ready=0. The combinational ALU evaluates the captured operands. On exit, result/flags load and result_valid pulses, then return to ON. A pending sleep_req is honoured only after returning to ON.
- ISO: iso_en=1, alu_pwr_en=1 for ISO_CYCLES cycles, then PWR_DN.
- PWR_DN: alu_pwr_en=0, iso_en=1. Waits for pwr_ack=0, then goes to OFF.
- Idle counter: counts ON cycles without a handshake and saturates at IDLE_TIMEOUT. It clears on a handshake and on entry to ON.
- Opcodes, all arithmetic modulo 2^WIDTH:
  - 0 ADD: carry = carry-out.
  - 1 SUB a-b: carry = borrow (a<b).
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT a.
  - 6 SHL a by b[log2(WIDTH)-1:0].
  - 7 SHR logical, same shift amount.
  - 8 MUL: low WIDTH bits of a*b.
  - 9 PASS b.
  - 10–15: illegal. Result 0, err=1.
- zero = (result==0). carry=0 for all non-ADD/SUB opcodes. err=0 for legal opcodes.
- The retention register loads only when iso_en=0 and alu_pwr_en=1 on BUSY exit. In all other cases the ALU output reaching it is clamped to 0 and not loaded.

## Timing
- Reset values: state OFF, pwr_state=0, alu_pwr_en=0, iso_en=1, in_ready=0, result=0, flags=0, result_valid=0, idle count 0.
- rst_n low in any state (including BUSY or mid-transition) forces OFF at the next edge. The in-flight result is discarded and the retention register cleared.
- Operation latency: handshake in cycle n gives result/flags/result_valid in cycle n+2. in_ready=1 again in cycle n+2. Throughput is one operation per 2 cycles.
- Wake with pwr_ack already 1: in_valid in OFF at cycle n gives PWR_UP at n+1, DEISO at n+2..n+1+ISO_CYCLES, and ON (in_ready=1) at n+2+ISO_CYCLES. Each extra cycle of pwr_ack=0 in PWR_UP adds one cycle.
- Auto sleep: in ON with no traffic, ISO is entered IDLE_TIMEOUT+1 cycles after ON entry.
- Sleep request: sleep_req high in ON cycle n (no handshake) gives ISO at n+1. PWR_DN is entered after ISO_CYCLES cycles. OFF is entered the cycle after pwr_ack=0 is sampled.
- sleep_req dropping during ISO or PWR_DN does not abort the sequence. The block reaches OFF before waking again.
- result/flags hold unchanged through ISO, PWR_DN, OFF and wake, until the next BUSY exit.
- iso_en is never 0 while alu_pwr_en=0 or pwr_ack=0.

## Test plan
All scenarios use WIDTH=16, ISO_CYCLES=2, IDLE_TIMEOUT=8, and a pwr_ack model that follows alu_pwr_en 3 cycles late.
- Cold wake + ADD: reset, then in_valid a=0xFFFF b=0x0001 op=0 → state passes 1,2,3; result=0x0000, flags=3'b011, one result_valid pulse 2 cycles after the handshake.
- Op sweep: in ON, issue SUB 0x0003-0x0005, MUL 0x0100*0x0101, SHL 0x0001 by 0x0013, op=12 → results in order:
  - SUB: 0xFFFE, carry=1.
  - MUL: 0x0100.
  - SHL: 0x0008.
  - op=12: 0x0000, flags=3'b101.
- Idle timeout: after one op, hold in_valid=0 → ISO exactly 9 cycles after ON entry, then OFF. result is still 0x0000 from the last op and holds through OFF.
- Sleep vs traffic: assert sleep_req and in_valid together in ON → the op is accepted, completes with result_valid, then ISO the cycle after returning to ON. In OFF with sleep_req=1 and in_valid=1 → stays OFF.
- Reset mid-op: rst_n low during BUSY → next cycle shows OFF, alu_pwr_en=0, iso_en=1, result=0, and no result_valid pulse.
- Isolation invariant: random traffic/sleep over 5000 cycles → never iso_en=0 with alu_pwr_en=0 or pwr_ack=0, and result changes only on result_valid cycles.
